serial_tx8: RTL and testbench

//   Parallel-in, serial-out frame transmitter; the send end of the 8-bit register link.

---
 rtl/serial_tx8_if.sv | 30 +++
 rtl/serial_tx8.sv | 123 ++++++++++++
 tb/tb_serial_tx8.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_tx8_if.sv
// rtl/serial_tx8_if.sv - parallel-load / serial-out link bundle for serial_tx8
// Purpose: groups the word/load request and the serial line status of the transmitter.
// Signals: D (parallel word), load (send request), tx (serial line),
//          busy (frame in flight), done (one-cycle completion pulse).
// Modports: master drives D/load and observes tx/busy/done; slave is the transmitter.
interface serial_tx8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             load;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output D,
        output load,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  D,
        input  load,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx8.sv
// rtl/serial_tx8.sv - parallel-in serial-out frame transmitter (start, WIDTH data LSB first, stop)
// Purpose: captures bus.D on an accepted load and shifts it out on bus.tx,
//          every bit held for CLKS_PER_BIT cycles; all outputs are registered.
// Ports:   clk  - rising-edge clock
//          CLR  - asynchronous active-high clear, forces idle (tx=1, busy=0, done=0)
//          bus  - slave side of serial_tx8_if (D, load in; tx, busy, done out)
module serial_tx8 #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        CLR,
    serial_tx8_if.slave bus
);
    localparam int DW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // tx is registered, so each transition loads the value of the *next* bit;
    // that keeps every bit on the line for exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = START;
                    shift_d = bus.D;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STOP: begin
                // load seen on this edge is ignored: the state is still STOP,
                // which gives the mandatory one idle cycle between frames.
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_tx8.sv
// tb/tb_serial_tx8.sv - scoreboard testbench for serial_tx8
module tb_serial_tx8;
    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int L   = (W + 2) * CPB;

    logic clk;
    logic clr;

    serial_tx8_if #(.WIDTH(W)) bus ();

    serial_tx8 #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected {tx, busy, done} after each clock edge
    logic [2:0] exp_q[$];

    // frame-level reference: bits of the frame in flight and cycles since accept
    logic fbits[W + 2];
    int   pos;
    bit   active;
    int   model_done;
    int   done_seen;
    int   busy_seen;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // One clock cycle: drive inputs for the next edge and predict the outputs after it.
    task automatic step(input logic ld, input logic [W-1:0] d, input logic c);
        logic prev_clr;
        @(negedge clk);
        #1;
        prev_clr = clr;
        bus.load = ld;
        bus.D    = d;
        clr      = c;
        if (c) begin
            active = 1'b0;
            exp_q.push_back(3'b100);
        end else if (active) begin
            pos++;
            if (pos == L) begin
                active = 1'b0;
                model_done++;
                exp_q.push_back(3'b101);
            end else begin
                exp_q.push_back({fbits[pos / CPB], 1'b1, 1'b0});
            end
        end else if (ld) begin
            active = 1'b1;
            pos    = 0;
            fbits[0] = 1'b0;
            for (int i = 0; i < W; i++) fbits[i + 1] = d[i];
            fbits[W + 1] = 1'b1;
            exp_q.push_back(3'b010);
        end else begin
            exp_q.push_back(3'b100);
        end
        if (c && !prev_clr) begin
            #1;
            chk("clr_async_tx_busy_done", int'({bus.tx, bus.busy, bus.done}), 4);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({bus.tx, bus.busy, bus.done} !== e) begin
                errors++;
                $display("FAIL cycle_out t=%0t: got tx/busy/done=%b%b%b expected %b",
                         $time, bus.tx, bus.busy, bus.done, e);
            end
            if (bus.done === 1'b1) done_seen++;
            if (bus.busy === 1'b1) busy_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0;
        active     = 1'b0;
        pos        = 0;
        model_done = 0;
        done_seen  = 0;
        busy_seen  = 0;
        bus.load   = 1'b0;
        bus.D      = '0;
        clr        = 1'b0;
        #1 clr     = 1'b1;
        #1;
        chk("reset_tx_busy_done", int'({bus.tx, bus.busy, bus.done}), 4);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // single frame 0x56
        sync();
        d0 = done_seen; b0 = busy_seen;
        step(1'b1, 8'b0101_0110, 1'b0);
        repeat (45) step(1'b0, 8'b0101_0110, 1'b0);
        sync();
        chk("single_busy_cycles", busy_seen - b0, 40);
        chk("single_done_pulses", done_seen - d0, 1);

        // D changes mid-frame
        d0 = done_seen;
        step(1'b1, 8'b1111_0000, 1'b0);
        repeat (10) step(1'b0, 8'b1111_0000, 1'b0);
        repeat (35) step(1'b0, 8'h00, 1'b0);
        sync();
        chk("dchange_done_pulses", done_seen - d0, 1);

        // load during data bit 3 is ignored
        d0 = done_seen; b0 = busy_seen;
        step(1'b1, 8'h3C, 1'b0);
        repeat (17) step(1'b0, 8'h3C, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        repeat (30) step(1'b0, 8'hAA, 1'b0);
        sync();
        chk("busyload_done_pulses", done_seen - d0, 1);
        chk("busyload_busy_cycles", busy_seen - b0, 40);

        // continuous load: two back-to-back frames with one idle cycle
        d0 = done_seen; b0 = busy_seen;
        repeat (2 * (L + 1)) step(1'b1, 8'hFF, 1'b0);
        repeat (3) step(1'b0, 8'hFF, 1'b0);
        sync();
        chk("continuous_done_pulses", done_seen - d0, 2);
        chk("continuous_busy_cycles", busy_seen - b0, 80);

        // CLR during data bit 5, then a clean frame
        d0 = done_seen;
        step(1'b1, 8'hC3, 1'b0);
        repeat (25) step(1'b0, 8'hC3, 1'b0);
        step(1'b0, 8'hC3, 1'b1);
        step(1'b0, 8'hC3, 1'b1);
        repeat (2) step(1'b0, 8'hC3, 1'b0);
        sync();
        chk("abort_no_done", done_seen - d0, 0);
        step(1'b1, 8'h01, 1'b0);
        repeat (44) step(1'b0, 8'h01, 1'b0);
        sync();
        chk("after_abort_done_pulses", done_seen - d0, 1);

        // randomized traffic
        repeat (500) begin
            step(($urandom_range(0, 5) == 0), W'($urandom), ($urandom_range(0, 199) == 0));
        end
        repeat (L + 2) step(1'b0, 8'h00, 1'b0);
        sync();
        chk("random_done_total", done_seen, model_done);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
